// File: rtl/switch_allocator_rr_pkg.sv
// Shared sizing and types for the five-port NoC router switch allocator.
package noc_params;

  localparam int PORT_NUM  = 5;
  localparam int VC_NUM    = 2;
  localparam int PORT_SIZE = $clog2(PORT_NUM);
  localparam int VC_SIZE   = $clog2(VC_NUM);

  typedef logic [PORT_SIZE-1:0] port_t;
  typedef logic [VC_SIZE-1:0]   vc_t;

  // One full allocation decision: per-input read selection and per-output crossbar setup.
  typedef struct packed {
    logic  [PORT_NUM-1:0] valid_sel;
    vc_t   [PORT_NUM-1:0] vc_sel;
    logic  [PORT_NUM-1:0] xb_valid;
    port_t [PORT_NUM-1:0] xb_sel;
    vc_t   [PORT_NUM-1:0] ds_vc;
  } sa_grant_t;

endpackage

// File: rtl/switch_allocator_rr_if.sv
// Request/grant bundle between input-port VC state, the switch allocator and the crossbar.
interface switch_allocator_rr_if;
  import noc_params::*;

  logic  [PORT_NUM-1:0][VC_NUM-1:0] req_i;
  port_t [PORT_NUM-1:0][VC_NUM-1:0] out_port_i;
  vc_t   [PORT_NUM-1:0][VC_NUM-1:0] ds_vc_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0] on_off_i;

  logic  [PORT_NUM-1:0] valid_sel_o;
  vc_t   [PORT_NUM-1:0] vc_sel_o;
  logic  [PORT_NUM-1:0] xb_valid_o;
  port_t [PORT_NUM-1:0] xb_sel_o;
  vc_t   [PORT_NUM-1:0] ds_vc_o;

  modport master (
    output req_i, out_port_i, ds_vc_i, on_off_i,
    input  valid_sel_o, vc_sel_o, xb_valid_o, xb_sel_o, ds_vc_o
  );

  modport slave (
    input  req_i, out_port_i, ds_vc_i, on_off_i,
    output valid_sel_o, vc_sel_o, xb_valid_o, xb_sel_o, ds_vc_o
  );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter owning its priority pointer; the pointer moves past the
// current winner only when the caller confirms the grant through update.
module round_robin_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         update,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic          w_found;
  int            w_idx;

  always_comb begin
    grant   = '0;
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = PW'(w_idx);
      end
    end
    if (w_found) grant[w_win] = 1'b1;
  end

  // Explicit wrap so non-power-of-two sizes never land on an unused slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (update && w_found) begin
      r_ptr <= (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
    end
  end

endmodule

// File: rtl/switch_allocator_rr.sv
// Separable input-first switch allocator: VC round-robin per input, then input
// round-robin per output. Build option SWITCH_ALLOC_OUTPUT_REG_EN registers all outputs.
module switch_allocator_rr
  import noc_params::*;
(
  input logic                  clk,
  input logic                  rst,
  switch_allocator_rr_if.slave sa_bus
);

  logic  [PORT_NUM-1:0][VC_NUM-1:0]   w_elig;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]   w_vc_gnt;
  vc_t   [PORT_NUM-1:0]               w_vc_idx;
  logic  [PORT_NUM-1:0]               w_in_valid;
  port_t [PORT_NUM-1:0]               w_win_port;
  logic  [PORT_NUM-1:0][PORT_NUM-1:0] w_out_req;  // [output][input]
  logic  [PORT_NUM-1:0][PORT_NUM-1:0] w_in_gnt;   // [output][input]
  logic  [PORT_NUM-1:0]               w_in_upd;
  sa_grant_t                          w_res;
  sa_grant_t                          w_out;

  genvar gi, gv;
  generate
    for (gi = 0; gi < PORT_NUM; gi++) begin : g_in
      for (gv = 0; gv < VC_NUM; gv++) begin : g_vc
        // Unused port encodings are never eligible.
        assign w_elig[gi][gv] = sa_bus.req_i[gi][gv]
            && (int'(sa_bus.out_port_i[gi][gv]) < PORT_NUM)
            && sa_bus.on_off_i[sa_bus.out_port_i[gi][gv]][sa_bus.ds_vc_i[gi][gv]];
      end

      round_robin_arbiter #(.N(VC_NUM)) u_vc_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (w_elig[gi]),
        .update (w_in_upd[gi]),
        .grant  (w_vc_gnt[gi])
      );
    end

    for (gi = 0; gi < PORT_NUM; gi++) begin : g_out
      round_robin_arbiter #(.N(PORT_NUM)) u_port_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (w_out_req[gi]),
        .update (|w_out_req[gi]),
        .grant  (w_in_gnt[gi])
      );
    end
  endgenerate

  always_comb begin
    w_vc_idx   = '0;
    w_in_valid = '0;
    w_win_port = '0;
    w_out_req  = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (w_vc_gnt[p][v]) w_vc_idx[p] = vc_t'(v);
      end
      w_in_valid[p] = |w_vc_gnt[p];
      w_win_port[p] = sa_bus.out_port_i[p][w_vc_idx[p]];
      for (int o = 0; o < PORT_NUM; o++) begin
        w_out_req[o][p] = w_in_valid[p] && (w_win_port[p] == port_t'(o));
      end
    end
  end

  // A stage-1 winner that loses stage 2 gets no update, so its VC pointer holds.
  always_comb begin
    w_res    = '0;
    w_in_upd = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      for (int p = 0; p < PORT_NUM; p++) begin
        if (w_in_gnt[o][p]) begin
          w_res.xb_valid[o]  = 1'b1;
          w_res.xb_sel[o]    = port_t'(p);
          w_res.ds_vc[o]     = sa_bus.ds_vc_i[p][w_vc_idx[p]];
          w_res.valid_sel[p] = 1'b1;
          w_res.vc_sel[p]    = w_vc_idx[p];
          w_in_upd[p]        = 1'b1;
        end
      end
    end
  end

`ifdef SWITCH_ALLOC_OUTPUT_REG_EN
  sa_grant_t r_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res <= '0;
    end else begin
      r_res <= w_res;
    end
  end

  assign w_out = r_res;
`else
  assign w_out = rst ? '0 : w_res;
`endif

  assign sa_bus.valid_sel_o = w_out.valid_sel;
  assign sa_bus.vc_sel_o    = w_out.vc_sel;
  assign sa_bus.xb_valid_o  = w_out.xb_valid;
  assign sa_bus.xb_sel_o    = w_out.xb_sel;
  assign sa_bus.ds_vc_o     = w_out.ds_vc;

endmodule

// File: doc/switch_allocator_rr.md
# switch_allocator_rr

Separable input-first switch allocator for the five-port NoC router. Each cycle it picks at most one virtual channel per input port and at most one input per output port, honouring downstream on/off flow control. It drives the input ports' read selection and the crossbar's per-output input selection. It sits between the input ports' VC state (valid, non-empty, routed) and the crossbar and switch-traversal stage.

## Interface
- PORT_NUM, default 5, number of router ports, indexed by `port_t` encoding.
- VC_NUM, default 2, virtual channels per port.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  PORT_NUM x VC_NUM  request from each VC: VC allocated, buffer non-empty.
- out_port_i  in  PORT_NUM x VC_NUM x PORT_SIZE  routed output port of each VC.
- ds_vc_i  in  PORT_NUM x VC_NUM x VC_SIZE  downstream VC allocated to each VC.
- on_off_i  in  PORT_NUM x VC_NUM  downstream on/off per output port and downstream VC; 1 means it can accept.
- valid_sel_o  out  PORT_NUM  per input port: a grant is issued.
- vc_sel_o  out  PORT_NUM x VC_SIZE  per input port: granted VC.
- xb_valid_o  out  PORT_NUM  per output port: a flit traverses.
- xb_sel_o  out  PORT_NUM x PORT_SIZE  per output port: source input port.
- ds_vc_o  out  PORT_NUM x VC_SIZE  per output port: VC id to stamp on the outgoing flit.

## Operation
- Eligibility: VC (p,v) is eligible iff `req_i[p][v] && on_off_i[out_port_i[p][v]][ds_vc_i[p][v]]`.
- Stage 1, per input p:
  - Round-robin over eligible VCs, starting at `in_ptr[p]`.
  - The winner's `out_port_i` forms a request to stage 2.
- Stage 2, per output o:
  - Round-robin over inputs whose stage-1 winner targets o, starting at `out_ptr[o]`.
- Final grant for (p,v) on o:
  - `valid_sel_o[p]=1`, `vc_sel_o[p]=v`.
  - `xb_valid_o[o]=1`, `xb_sel_o[o]=p`, `ds_vc_o[o]=ds_vc_i[p][v]`.
- Pointer update, only on a final grant:
  - `in_ptr[p] <= (v+1) mod VC_NUM`.
  - `out_ptr[o] <= (p+1) mod PORT_NUM`.
  - An input losing in stage 2 keeps its `in_ptr`.
  - Wrap-around uses explicit compare, not power-of-two truncation.
- Ungranted output fields:
  - `vc_sel_o`, `xb_sel_o` and `ds_vc_o` are 0 where the matching valid is 0.
- No eligible request: all valids are 0 and pointers hold.
- A U-turn (out_port equals own input) is granted like any other request.
- Guarantees:
  - Never two grants per input.
  - Never two inputs per output.
  - Never a grant to an off downstream VC.

## Timing
- Reset, asynchronous: all outputs 0, all `in_ptr` 0, all `out_ptr` 0. Reset asserted mid-operation clears pending registered grants immediately.
- Grant latency is 1 cycle with the macro defined, 0 without; see Configuration.
- Pointers always update at the clock edge following the arbitration decision.
- `on_off_i` is sampled in the same cycle as `req_i`. A VC turning off blocks its grant in that cycle.
- Persistent requests are served fairly: with N contending inputs on one output, each is granted within N cycles.

## Configuration
- `SWITCH_ALLOC_OUTPUT_REG_EN` defined:
  - All outputs are flip-flops loaded from the arbitration result.
  - Latency is 1 cycle and outputs are glitch-free.
  - The requester must deassert `req_i` for a flit already granted but not yet read; the input port accounts for this by pending-read tracking.
- `SWITCH_ALLOC_OUTPUT_REG_EN` undefined:
  - Outputs are combinational from inputs and pointers, latency 0.
  - Pointers remain registered.

## Structure
- Package `noc_params`: PORT_NUM, VC_NUM, `PORT_SIZE = $clog2(PORT_NUM)`, `VC_SIZE = $clog2(VC_NUM)`, `port_t`.
- Sub-module `round_robin_arbiter`:
  - Parameter N.
  - Ports: clk, rst, `req[N]`, `update`, `grant[N]` one-hot.
  - Owns its own pointer, which advances past the winner when `update` is asserted.
- Instantiated PORT_NUM times at VC_NUM width and PORT_NUM times at PORT_NUM width.

## Test plan
Defaults PORT_NUM=5, VC_NUM=2, macro defined.
- Reset: assert rst with `req_i` all 1, deassert, then hold `req_i` at 0 -> all outputs 0 while reset is active and after release.
- Single request: `req_i[1][0]=1`, out_port 4, ds_vc 1, `on_off_i[4][1]=1` -> next cycle `valid_sel_o[1]=1`, `vc_sel_o[1]=0`, `xb_valid_o[4]=1`, `xb_sel_o[4]=1`, `ds_vc_o[4]=1`.
- Output contention: inputs 0, 2 and 3 all hold a request to output 1 for 6 cycles -> grants to output 1 rotate 0,2,3,0,2,3.
- VC round-robin: `req_i[2][0]` and `req_i[2][1]` held, targeting different outputs -> `vc_sel_o[2]` alternates 0,1,0,1.
- Flow control: `on_off_i[4][0]=0`, VC targets (4,0) -> no grant; raise on_off -> grant one cycle later.
- Parallel non-conflicting: inputs 0..4 target outputs 4,3,2,1,0 -> all five `xb_valid_o` set in the same cycle with correct `xb_sel_o`.
